// File: rtl/rng_word_collector_if.sv
// Bus bundle between the random-word collector, its TRNG source and its word consumer.
//
// Handshakes:
//   raw bit : the collector takes RANDOM in a cycle where BIT_READY=1 and its own
//             ACK=0, then pulses ACK for exactly the next cycle; BIT_READY seen
//             while ACK=1 is ignored, so at most one raw bit is taken per 2 cycles.
//   word    : WORD/WORD_VALID hold steady until WORD_READY=1; a transfer happens in
//             any cycle with WORD_VALID=1 and WORD_READY=1 (WORD_READY may already
//             be high when WORD_VALID rises).
interface rng_word_collector_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic             EN;
    logic             RANDOM;
    logic             BIT_READY;
    logic             ACK;
    logic [WIDTH-1:0] WORD;
    logic             WORD_VALID;
    logic             WORD_READY;
    logic             BUSY;
    logic             FAULT;

    // Collector side
    modport master (
        input  START, RANDOM, BIT_READY, WORD_READY,
        output EN, ACK, WORD, WORD_VALID, BUSY, FAULT
    );

    // Environment side (TRNG, controller and word consumer)
    modport slave (
        output START, RANDOM, BIT_READY, WORD_READY,
        input  EN, ACK, WORD, WORD_VALID, BUSY, FAULT
    );
endinterface

// File: rtl/rng_word_collector.sv
// Collects raw TRNG bits into a WIDTH-bit word (LSB first), with optional von
// Neumann debiasing and a repetition-count health test that latches a fault.
module rng_word_collector #(
    parameter int WIDTH      = 16,
    parameter int DEBIAS     = 0,
    parameter int CONTINUOUS = 0,
    parameter int REP_LIMIT  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    rng_word_collector_if.master  bus,
    output logic [1:0]            dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        HOLD     = 2'd2,
        FAULT_ST = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [WIDTH-1:0] word, word_n;
    logic            pair_full, pair_full_n;
    logic            pair_bit, pair_bit_n;
    logic [RW-1:0]   rep_cnt, rep_cnt_n;
    logic            last_bit, last_bit_n;
    logic            ack, ack_n;
    logic            en_q, busy_q, valid_q, fault_q;
    logic            take, emit, emit_bit, restart;

    // Next-state, bit intake, debiasing, word assembly and repetition test
    always_comb begin
        state_n     = state;
        count_n     = count;
        word_n      = word;
        pair_full_n = pair_full;
        pair_bit_n  = pair_bit;
        rep_cnt_n   = rep_cnt;
        last_bit_n  = last_bit;
        ack_n       = 1'b0;
        take        = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;
        restart     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_n = COLLECT;
                    restart = 1'b1;
                end
            end
            COLLECT: begin
                // One bit per handshake: a bit offered while ACK is high is not taken.
                take = bus.BIT_READY && !ack;
                if (take) begin
                    ack_n = 1'b1;
                    // Run length of identical raw bits; a cleared counter starts a new run.
                    if (rep_cnt != '0 && bus.RANDOM == last_bit) begin
                        rep_cnt_n = rep_cnt + 1'b1;
                    end else begin
                        rep_cnt_n = RW'(1);
                    end
                    last_bit_n = bus.RANDOM;

                    if (DEBIAS == 0) begin
                        emit     = 1'b1;
                        emit_bit = bus.RANDOM;
                    end else if (!pair_full) begin
                        pair_full_n = 1'b1;
                        pair_bit_n  = bus.RANDOM;
                    end else begin
                        // 01 -> 0, 10 -> 1: the emitted bit equals the first of the pair.
                        pair_full_n = 1'b0;
                        if (pair_bit != bus.RANDOM) begin
                            emit     = 1'b1;
                            emit_bit = pair_bit;
                        end
                    end

                    if (emit) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (count == CW'(i)) word_n[i] = emit_bit;
                        end
                        count_n = count + 1'b1;
                    end

                    // A health-test failure wins over a word completing on the same bit.
                    if (rep_cnt_n == RW'(REP_LIMIT)) begin
                        state_n = FAULT_ST;
                        word_n  = '0;
                    end else if (count_n == CW'(WIDTH)) begin
                        state_n = HOLD;
                    end
                end
                // START restarts the word; an in-flight ACK still goes out.
                if (bus.START) begin
                    state_n = COLLECT;
                    restart = 1'b1;
                end
            end
            HOLD: begin
                if (bus.WORD_READY) begin
                    if (CONTINUOUS != 0) begin
                        state_n = COLLECT;
                        restart = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            FAULT_ST: begin
                if (bus.START) begin
                    state_n = COLLECT;
                    restart = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (restart) begin
            count_n     = '0;
            word_n      = '0;
            pair_full_n = 1'b0;
            rep_cnt_n   = '0;
        end
    end

    // State and datapath registers; status outputs are registered decodes of the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            word      <= '0;
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
            rep_cnt   <= '0;
            last_bit  <= 1'b0;
            ack       <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            word      <= word_n;
            pair_full <= pair_full_n;
            pair_bit  <= pair_bit_n;
            rep_cnt   <= rep_cnt_n;
            last_bit  <= last_bit_n;
            ack       <= ack_n;
            en_q      <= (state_n == COLLECT);
            busy_q    <= (state_n == COLLECT);
            valid_q   <= (state_n == HOLD);
            fault_q   <= (state_n == FAULT_ST);
        end
    end

    assign bus.EN         = en_q;
    assign bus.ACK        = ack;
    assign bus.WORD       = word;
    assign bus.WORD_VALID = valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.FAULT      = fault_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_rng_word_collector.sv
// Directed bench for rng_word_collector: three instances cover raw collection with
// a short repetition limit, debiased collection, and continuous mode.
module tb_rng_word_collector;
    logic clk;
    logic rst;

    // Per-instance stimulus (0: W8 raw REP4, 1: W4 debias, 2: W8 continuous)
    logic start_d [3];
    logic rnd_d   [3];
    logic brdy_d  [3];
    logic wrdy_d  [3];

    // Per-instance observed outputs, words zero-extended to 8 bits
    logic       en_o   [3];
    logic       ack_o  [3];
    logic       wv_o   [3];
    logic       busy_o [3];
    logic       fault_o[3];
    logic [7:0] word_o [3];
    logic [1:0] st_o   [3];

    int         ack_cnt [3];
    int         vectors;
    int         miscompares;
    logic [7:0] exp_q [$];
    logic [7:0] last_word;

    rng_word_collector_if #(.WIDTH(8)) if0 ();
    rng_word_collector_if #(.WIDTH(4)) if1 ();
    rng_word_collector_if #(.WIDTH(8)) if2 ();

    rng_word_collector #(.WIDTH(8), .DEBIAS(0), .CONTINUOUS(0), .REP_LIMIT(4)) u0 (
        .CLK(clk), .RST(rst), .bus(if0.master), .dbg_state(st_o[0])
    );
    rng_word_collector #(.WIDTH(4), .DEBIAS(1), .CONTINUOUS(0), .REP_LIMIT(32)) u1 (
        .CLK(clk), .RST(rst), .bus(if1.master), .dbg_state(st_o[1])
    );
    rng_word_collector #(.WIDTH(8), .DEBIAS(0), .CONTINUOUS(1), .REP_LIMIT(32)) u2 (
        .CLK(clk), .RST(rst), .bus(if2.master), .dbg_state(st_o[2])
    );

    assign if0.START = start_d[0];  assign if0.RANDOM = rnd_d[0];
    assign if0.BIT_READY = brdy_d[0]; assign if0.WORD_READY = wrdy_d[0];
    assign if1.START = start_d[1];  assign if1.RANDOM = rnd_d[1];
    assign if1.BIT_READY = brdy_d[1]; assign if1.WORD_READY = wrdy_d[1];
    assign if2.START = start_d[2];  assign if2.RANDOM = rnd_d[2];
    assign if2.BIT_READY = brdy_d[2]; assign if2.WORD_READY = wrdy_d[2];

    assign en_o[0] = if0.EN; assign ack_o[0] = if0.ACK; assign wv_o[0] = if0.WORD_VALID;
    assign busy_o[0] = if0.BUSY; assign fault_o[0] = if0.FAULT; assign word_o[0] = if0.WORD;
    assign en_o[1] = if1.EN; assign ack_o[1] = if1.ACK; assign wv_o[1] = if1.WORD_VALID;
    assign busy_o[1] = if1.BUSY; assign fault_o[1] = if1.FAULT; assign word_o[1] = {4'b0, if1.WORD};
    assign en_o[2] = if2.EN; assign ack_o[2] = if2.ACK; assign wv_o[2] = if2.WORD_VALID;
    assign busy_o[2] = if2.BUSY; assign fault_o[2] = if2.FAULT; assign word_o[2] = if2.WORD;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ACK pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack_o[k] === 1'b1) ack_cnt[k] = ack_cnt[k] + 1;
        end
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        start_d[k] = 1'b1;
        tick();
        start_d[k] = 1'b0;
    endtask

    // Offer one raw bit and wait (bounded) for its ACK, then let ACK drop.
    task automatic send_bit(input int k, input logic b);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        brdy_d[k] = 1'b1;
        rnd_d[k]  = b;
        while (!got && n < 6) begin
            tick();
            n = n + 1;
            if (ack_o[k] === 1'b1) got = 1'b1;
        end
        brdy_d[k] = 1'b0;
        if (!got) chk("ack_wait", {63'd0, got}, 64'd1);
        tick();
    endtask

    // Wait (bounded) for WORD_VALID and compare WORD against the scoreboard head.
    task automatic check_word(input int k, input string tag);
        logic       got;
        int         n;
        logic [7:0] e;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            if (wv_o[k] === 1'b1) got = 1'b1;
            else begin
                tick();
                n = n + 1;
            end
        end
        chk({tag, "_valid"}, {63'd0, got}, 64'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, {32'd0, vectors});
        end else begin
            e = exp_q.pop_front();
            last_word = e;
            if (got) chk(tag, {56'd0, word_o[k]}, {56'd0, e});
        end
    endtask

    // Model the expected word, push it, feed the raw bits and check the result.
    task automatic run_word(input int k, input bit debias, input int width,
                            input logic [15:0] bits, input int n, input string tag);
        logic [7:0] e;
        int         cnt;
        logic       pend;
        logic       pb;
        int         a0;
        e = '0;
        cnt = 0;
        pend = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!debias) begin
                if (cnt < width) e[cnt] = bits[i];
                cnt = cnt + 1;
            end else if (!pend) begin
                pb = bits[i];
                pend = 1'b1;
            end else begin
                pend = 1'b0;
                if (pb != bits[i] && cnt < width) begin
                    e[cnt] = pb;
                    cnt = cnt + 1;
                end
            end
        end
        exp_q.push_back(e);
        a0 = ack_cnt[k];
        for (int i = 0; i < n; i++) send_bit(k, bits[i]);
        check_word(k, tag);
        chk({tag, "_acks"}, 64'(ack_cnt[k] - a0), 64'(n));
        chk({tag, "_en"}, {63'd0, en_o[k]}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_o[k]}, 64'd0);
    endtask

    task automatic transfer(input int k);
        wrdy_d[k] = 1'b1;
        tick();
        wrdy_d[k] = 1'b0;
    endtask

    initial begin
        int a0;
        vectors = 0;
        miscompares = 0;
        last_word = '0;
        for (int k = 0; k < 3; k++) begin
            start_d[k] = 1'b0; rnd_d[k] = 1'b0; brdy_d[k] = 1'b0; wrdy_d[k] = 1'b0;
            ack_cnt[k] = 0;
        end

        // Reset state of every instance
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_en", {63'd0, en_o[k]}, 64'd0);
            chk("rst_ack", {63'd0, ack_o[k]}, 64'd0);
            chk("rst_word", {56'd0, word_o[k]}, 64'd0);
            chk("rst_valid", {63'd0, wv_o[k]}, 64'd0);
            chk("rst_busy", {63'd0, busy_o[k]}, 64'd0);
            chk("rst_fault", {63'd0, fault_o[k]}, 64'd0);
            chk("rst_state", {62'd0, st_o[k]}, 64'd0);
        end

        // BIT_READY in IDLE is never acknowledged
        a0 = ack_cnt[0];
        brdy_d[0] = 1'b1;
        rnd_d[0] = 1'b1;
        repeat (4) tick();
        brdy_d[0] = 1'b0;
        chk("idle_no_ack", 64'(ack_cnt[0] - a0), 64'd0);

        // Raw 8-bit collection: 1,0,1,1,0,0,1,0
        pulse_start(0);
        chk("start_busy", {63'd0, busy_o[0]}, 64'd1);
        chk("start_en", {63'd0, en_o[0]}, 64'd1);
        chk("start_state", {62'd0, st_o[0]}, 64'd1);
        run_word(0, 1'b0, 8, 16'h004D, 8, "raw8");

        // START in HOLD is ignored
        pulse_start(0);
        chk("hold_start_valid", {63'd0, wv_o[0]}, 64'd1);
        chk("hold_start_state", {62'd0, st_o[0]}, 64'd2);
        chk("hold_start_word", {56'd0, word_o[0]}, {56'd0, last_word});

        // Transfer in one-shot mode returns to IDLE and keeps WORD
        transfer(0);
        chk("xfer_valid", {63'd0, wv_o[0]}, 64'd0);
        chk("xfer_state", {62'd0, st_o[0]}, 64'd0);
        chk("xfer_word_kept", {56'd0, word_o[0]}, {56'd0, last_word});
        chk("xfer_en", {63'd0, en_o[0]}, 64'd0);

        // Repetition fault: four identical bits with REP_LIMIT=4
        pulse_start(0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        chk("fault_flag", {63'd0, fault_o[0]}, 64'd1);
        chk("fault_en", {63'd0, en_o[0]}, 64'd0);
        chk("fault_valid", {63'd0, wv_o[0]}, 64'd0);
        chk("fault_busy", {63'd0, busy_o[0]}, 64'd0);
        chk("fault_word", {56'd0, word_o[0]}, 64'd0);
        chk("fault_state", {62'd0, st_o[0]}, 64'd3);
        a0 = ack_cnt[0];
        brdy_d[0] = 1'b1;
        wrdy_d[0] = 1'b1;
        repeat (3) tick();
        brdy_d[0] = 1'b0;
        wrdy_d[0] = 1'b0;
        chk("fault_no_ack", 64'(ack_cnt[0] - a0), 64'd0);
        chk("fault_sticky", {63'd0, fault_o[0]}, 64'd1);
        pulse_start(0);
        chk("fault_clear", {63'd0, fault_o[0]}, 64'd0);
        chk("fault_restart_busy", {63'd0, busy_o[0]}, 64'd1);

        // Reset after 3 of 8 bits discards the partial word
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        chk("partial_word", {56'd0, word_o[0]}, 64'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_en", {63'd0, en_o[0]}, 64'd0);
        chk("midrst_word", {56'd0, word_o[0]}, 64'd0);
        chk("midrst_busy", {63'd0, busy_o[0]}, 64'd0);
        chk("midrst_fault", {63'd0, fault_o[0]}, 64'd0);
        chk("midrst_valid", {63'd0, wv_o[0]}, 64'd0);
        chk("midrst_ack", {63'd0, ack_o[0]}, 64'd0);
        a0 = ack_cnt[0];
        repeat (2) tick();
        chk("midrst_no_ack", 64'(ack_cnt[0] - a0), 64'd0);
        pulse_start(0);
        run_word(0, 1'b0, 8, 16'h0096, 8, "after_rst");
        transfer(0);

        // START mid-collection restarts the word
        pulse_start(0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        pulse_start(0);
        chk("restart_word", {56'd0, word_o[0]}, 64'd0);
        run_word(0, 1'b0, 8, 16'h0069, 8, "restart");
        transfer(0);

        // Debiased 4-bit word: pairs 01,11,10,00,10,01
        pulse_start(1);
        run_word(1, 1'b1, 4, 16'h091E, 12, "debias");
        transfer(1);
        chk("debias_idle", {62'd0, st_o[1]}, 64'd0);

        // Continuous mode with a stalled consumer
        pulse_start(2);
        run_word(2, 1'b0, 8, 16'h002E, 8, "cont1");
        a0 = ack_cnt[2];
        brdy_d[2] = 1'b1;
        rnd_d[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_word", {56'd0, word_o[2]}, {56'd0, last_word});
            chk("stall_valid", {63'd0, wv_o[2]}, 64'd1);
        end
        brdy_d[2] = 1'b0;
        chk("stall_no_ack", 64'(ack_cnt[2] - a0), 64'd0);
        transfer(2);
        chk("cont_valid", {63'd0, wv_o[2]}, 64'd0);
        chk("cont_busy", {63'd0, busy_o[2]}, 64'd1);
        chk("cont_en", {63'd0, en_o[2]}, 64'd1);
        chk("cont_word_clr", {56'd0, word_o[2]}, 64'd0);
        run_word(2, 1'b0, 8, 16'h00A5, 8, "cont2");
        transfer(2);
        chk("cont_recollect", {62'd0, st_o[2]}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rng_word_collector.md
RNG_WORD_COLLECTOR -- requirements
Module: rng_word_collector

Interface
REQ-001 Parameter WIDTH, default 16, word length in bits (2..64).
REQ-002 Parameter DEBIAS, default 0; 1 enables von Neumann pair debiasing of raw bits.
REQ-003 Parameter CONTINUOUS, default 0; 1 restarts collection automatically after each word is consumed.
REQ-004 Parameter REP_LIMIT, default 32, raw-bit repetition-count fault threshold (>=2).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; all state changes on rising CLK.
REQ-006 CLK  input  1  system clock.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 START  input  1  level, sampled each cycle; begins a collection or clears a fault.
REQ-009 EN  output  1  TRNG enable, registered.
REQ-010 RANDOM  input  1  raw bit from TRNG, valid while BIT_READY=1.
REQ-011 BIT_READY  input  1  TRNG raw-bit-available flag.
REQ-012 ACK  output  1  one-cycle registered pulse consuming the raw bit.
REQ-013 WORD  output  WIDTH  collected word, LSB first.
REQ-014 WORD_VALID  output  1  WORD complete and stable.
REQ-015 WORD_READY  input  1  consumer accepts WORD.
REQ-016 BUSY  output  1  high while in COLLECT.
REQ-017 FAULT  output  1  sticky repetition-test failure.

Function
REQ-018 States SHALL be IDLE, COLLECT, HOLD, FAULT_ST.
REQ-019 IDLE + START=1: next cycle state=COLLECT, EN=1, bit count=0, WORD=0, debias pair register empty, repetition counter=0.
REQ-020 COLLECT: a raw bit SHALL be taken in a cycle where BIT_READY=1 and ACK=0; ACK=1 on the following cycle only; BIT_READY while ACK=1 is ignored (one bit per handshake, max one raw bit per 2 cycles).
REQ-021 DEBIAS=0: each taken raw bit SHALL be written to WORD[count], count increments by 1.
REQ-022 DEBIAS=1: raw bits paired in order; pair 0,1 emits 0; pair 1,0 emits 1; pairs 0,0 and 1,1 emit nothing; emitted bit written to WORD[count].
REQ-023 Count width SHALL be clog2(WIDTH+1); when the emitted bit makes count=WIDTH, next cycle: state=HOLD, WORD_VALID=1, EN=0, BUSY=0.
REQ-024 HOLD: WORD and WORD_VALID SHALL stay constant until WORD_READY=1; WORD_READY may already be high when WORD_VALID rises (transfer in first HOLD cycle).
REQ-025 On transfer (WORD_VALID=1 and WORD_READY=1): WORD_VALID=0 next cycle; CONTINUOUS=1 -> COLLECT with REQ-019 clears; CONTINUOUS=0 -> IDLE, WORD retains last value.
REQ-026 START in COLLECT SHALL restart collection (REQ-019 clears, ACK of an in-flight bit still issued); START in HOLD SHALL be ignored.
REQ-027 Repetition test: counter of consecutive identical raw bits (pre-debias), reset to 1 on value change; reaching REP_LIMIT SHALL next cycle enter FAULT_ST: FAULT=1, EN=0, BUSY=0, WORD_VALID=0, WORD=0.
REQ-028 FAULT_ST: only START=1 (or RST) leaves; START SHALL clear FAULT and enter COLLECT per REQ-019.
REQ-029 WORD_READY outside HOLD SHALL have no effect; BIT_READY outside COLLECT SHALL produce no ACK.

Reset
REQ-030 RST=1 SHALL override all inputs including START; next cycle state=IDLE, EN=0, ACK=0, WORD=0, WORD_VALID=0, BUSY=0, FAULT=0, counters cleared.
REQ-031 RST mid-COLLECT or mid-HOLD SHALL discard partial/held word with no ACK issued after reset.

Verification
REQ-032 WIDTH=8, DEBIAS=0: START, raw bits 1,0,1,1,0,0,1,0 -> WORD=8'h4D, WORD_VALID=1, exactly 8 ACK pulses, EN=0.
REQ-033 WIDTH=4, DEBIAS=1: raw pairs 01,11,10,00,10,01 -> WORD=4'b0110 (emits 0,1,1,0 LSB first), 6 pairs = 12 ACKs.
REQ-034 WIDTH=8, REP_LIMIT=4: raw bits 1,1,1,1 -> FAULT=1, EN=0, WORD_VALID never set; START -> FAULT=0, BUSY=1.
REQ-035 CONTINUOUS=1, WORD_READY held 0 for 10 cycles after WORD_VALID -> WORD stable, no ACK; WORD_READY=1 -> next cycle WORD_VALID=0, BUSY=1, EN=1.
REQ-036 RST asserted after 3 of 8 bits -> all outputs 0 next cycle; subsequent START + 8 bits yields correct word with no stale bits.
